stream_enc: RTL and testbench

//   Transmit-side counterpart of the 4-lane one-counting accumulator. Accepts four

---
 rtl/stream_enc.sv | 166 ++++++++++++++++
 tb/tb_stream_enc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_enc.sv
// stream_enc: four-lane magnitude-to-pulse-stream serialiser.
//   Each accepted frame emits FRAME_LEN slots per lane; the number of 1s on a
//   lane equals min(val_i, FRAME_LEN). Frames may be issued back-to-back.
//
// Encoding is selected at build time by the macro STREAM_ENC_SPREAD_EN:
//   defined     : per-lane error-accumulator encoding (ones spread evenly)
//   not defined : thermometer encoding, bit = (slot < v_i)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   en_in      load request, accepted on an edge where en_in && ready
//   val1..val4 lane magnitudes, sampled on the accept edge only
//   ready      block can accept a frame this cycle (combinational)
//   out1..out4 registered serial lane bits
//   en_out     registered, high while out1..4 carry a valid slot
//   frame_end  registered, high during the last slot of a frame
//   sat        registered, high for the frame if any val exceeded FRAME_LEN
module stream_enc #(
    parameter int unsigned FRAME_LEN = 32,
    parameter int unsigned VAL_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic [VAL_W-1:0] val1,
    input  logic [VAL_W-1:0] val2,
    input  logic [VAL_W-1:0] val3,
    input  logic [VAL_W-1:0] val4,
    output logic             ready,
    output logic             out1,
    output logic             out2,
    output logic             out3,
    output logic             out4,
    output logic             en_out,
    output logic             frame_end,
    output logic             sat
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam int unsigned LANES = 4;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] PENULT = CNT_W'(FRAME_LEN - 2);
    localparam logic [VAL_W-1:0] FULL   = VAL_W'(FRAME_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [VAL_W-1:0]  v_q     [LANES];
    logic [VAL_W-1:0]  val_in  [LANES];
    logic [VAL_W-1:0]  v_clamp [LANES];
    logic [VAL_W-1:0]  v_eff   [LANES];
    logic [LANES-1:0]  bits_c;
    logic              at_last;
    logic              accept;
    logic              sat_c;

    assign val_in[0] = val1;
    assign val_in[1] = val2;
    assign val_in[2] = val3;
    assign val_in[3] = val4;

    // Handshake: a new frame may start when idle or in the final slot.
    assign at_last = (state == RUN) && (cnt == LAST);
    assign ready   = !rst && ((state == IDLE) || at_last);
    assign accept  = en_in && ready;

    // Clamp incoming magnitudes; the slot being produced uses the new values
    // on an accept edge and the latched ones otherwise.
    always_comb begin
        sat_c = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            v_clamp[i] = (val_in[i] > FULL) ? FULL : val_in[i];
            sat_c      = sat_c | (val_in[i] > FULL);
            v_eff[i]   = accept ? v_clamp[i] : v_q[i];
        end
    end

`ifdef STREAM_ENC_SPREAD_EN
    localparam logic [VAL_W:0] FULL_ACC = (VAL_W+1)'(FRAME_LEN);

    logic [VAL_W:0] acc_q [LANES];
    logic [VAL_W:0] acc_n [LANES];
    logic [VAL_W:0] sum_c [LANES];

    // Error accumulator: add v each slot, emit a 1 and wrap on overflow.
    // The accumulator restarts from zero for slot 0 of every frame.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sum_c[i]  = (accept ? '0 : acc_q[i]) + (VAL_W+1)'(v_eff[i]);
            bits_c[i] = (sum_c[i] >= FULL_ACC);
            acc_n[i]  = bits_c[i] ? (sum_c[i] - FULL_ACC) : sum_c[i];
        end
    end

    // Accumulators advance only on edges that produce a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
        end else if (accept || ((state == RUN) && !at_last)) begin
            for (int i = 0; i < LANES; i++) acc_q[i] <= acc_n[i];
        end
    end
`else
    logic [CNT_W-1:0] slot_c;

    // Thermometer: the first v slots of the frame are 1.
    assign slot_c = accept ? '0 : (cnt + CNT_W'(1));

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bits_c[i] = (VAL_W'(slot_c) < v_eff[i]);
        end
    end
`endif

    // Frame sequencer with registered outputs; cnt is the slot on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            for (int i = 0; i < LANES; i++) v_q[i] <= '0;
            out1      <= 1'b0;
            out2      <= 1'b0;
            out3      <= 1'b0;
            out4      <= 1'b0;
            en_out    <= 1'b0;
            frame_end <= 1'b0;
            sat       <= 1'b0;
        end else if (accept) begin
            state     <= RUN;
            cnt       <= '0;
            for (int i = 0; i < LANES; i++) v_q[i] <= v_clamp[i];
            out1      <= bits_c[0];
            out2      <= bits_c[1];
            out3      <= bits_c[2];
            out4      <= bits_c[3];
            en_out    <= 1'b1;
            frame_end <= 1'b0;
            sat       <= sat_c;
        end else if ((state == RUN) && !at_last) begin
            cnt       <= cnt + CNT_W'(1);
            out1      <= bits_c[0];
            out2      <= bits_c[1];
            out3      <= bits_c[2];
            out4      <= bits_c[3];
            en_out    <= 1'b1;
            frame_end <= (cnt == PENULT);
        end else begin
            state     <= IDLE;
            cnt       <= '0;
            out1      <= 1'b0;
            out2      <= 1'b0;
            out3      <= 1'b0;
            out4      <= 1'b0;
            en_out    <= 1'b0;
            frame_end <= 1'b0;
            sat       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_enc.sv
// Bench for stream_enc: slot-level reference model plus directed frame checks.
module tb_stream_enc;

    localparam int F = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_in = 1'b0;
    logic [5:0] v1 = '0, v2 = '0, v3 = '0, v4 = '0;
    logic       ready, out1, out2, out3, out4, en_out, frame_end, sat;

    int total = 0;
    int bad   = 0;

    stream_enc #(.FRAME_LEN(F), .VAL_W(6)) dut (
        .clk(clk), .rst(rst), .en_in(en_in),
        .val1(v1), .val2(v2), .val3(v3), .val4(v4),
        .ready(ready), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .en_out(en_out), .frame_end(frame_end), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > F) ? F : v;
    endfunction

    // Ones of a frame are distributed as floor((s+1)v/F) - floor(sv/F) when
    // spread, or as a leading block of v ones otherwise.
    function automatic logic exp_bit(input int v, input int s);
`ifdef STREAM_ENC_SPREAD_EN
        return (((s + 1) * v) / F - (s * v) / F) != 0;
`else
        return s < v;
`endif
    endfunction

    // Reference model: which slot (if any) is on the outputs this cycle.
    int   m_slot = -1;
    int   m_v [4];
    logic m_sat = 1'b0;
    logic chk_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_slot = -1;
        end else if (en_in && (m_slot < 0 || m_slot == F - 1)) begin
            m_slot  = 0;
            m_v[0]  = clampv(int'(v1));
            m_v[1]  = clampv(int'(v2));
            m_v[2]  = clampv(int'(v3));
            m_v[3]  = clampv(int'(v4));
            m_sat   = (v1 > 6'(F)) || (v2 > 6'(F)) || (v3 > 6'(F)) || (v4 > 6'(F));
        end else if (m_slot >= 0 && m_slot < F - 1) begin
            m_slot++;
        end else begin
            m_slot = -1;
        end
    end

    logic [7:0] e_vec, a_vec;

    always @(negedge clk) begin
        if (chk_on) begin
            e_vec[7] = !rst && (m_slot < 0 || m_slot == F - 1);
            if (m_slot < 0) begin
                e_vec[6:0] = '0;
            end else begin
                e_vec[6] = 1'b1;
                e_vec[5] = (m_slot == F - 1);
                e_vec[4] = m_sat;
                e_vec[3] = exp_bit(m_v[3], m_slot);
                e_vec[2] = exp_bit(m_v[2], m_slot);
                e_vec[1] = exp_bit(m_v[1], m_slot);
                e_vec[0] = exp_bit(m_v[0], m_slot);
            end
            a_vec = {ready, en_out, frame_end, sat, out4, out3, out2, out1};
            chk("cycle", 32'(a_vec), 32'(e_vec));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_vals(input int a, input int b, input int c, input int d);
        v1 = 6'(a); v2 = 6'(b); v3 = 6'(c); v4 = 6'(d);
    endtask

    int          ones [4];
    int          en_cnt, fe_cnt, fe_pos, sat_cnt;
    logic [31:0] pat3;

    // Accept one frame from idle and record what the lanes emit.
    task automatic cap_frame(input int a, input int b, input int c, input int d);
        set_vals(a, b, c, d);
        en_in = 1'b1;
        step();
        en_in = 1'b0;
        for (int i = 0; i < 4; i++) ones[i] = 0;
        en_cnt = 0; fe_cnt = 0; fe_pos = -1; sat_cnt = 0; pat3 = '0;
        for (int s = 0; s < F; s++) begin
            en_cnt  += int'(en_out);
            sat_cnt += int'(sat);
            if (frame_end) begin fe_cnt++; fe_pos = s; end
            ones[0] += int'(out1); ones[1] += int'(out2);
            ones[2] += int'(out3); ones[3] += int'(out4);
            pat3[s] = out3;
            step();
        end
    endtask

    int fv [4];
    int t4_ones [4];
    int en_hi;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_on = 1'b1;
        rst = 1'b0;
        step();

        // Idle after reset release
        repeat (5) step();
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_en_out", 32'(en_out), 32'd0);
        chk("idle_outs", 32'({out4, out3, out2, out1}), 32'd0);

        // Basic frame
        cap_frame(0, 32, 16, 5);
        chk("t2_en_cnt", 32'(en_cnt), 32'd32);
        chk("t2_fe_cnt", 32'(fe_cnt), 32'd1);
        chk("t2_fe_pos", 32'(fe_pos), 32'd31);
        chk("t2_ones1", 32'(ones[0]), 32'd0);
        chk("t2_ones2", 32'(ones[1]), 32'd32);
        chk("t2_ones3", 32'(ones[2]), 32'd16);
        chk("t2_ones4", 32'(ones[3]), 32'd5);
        chk("t2_sat", 32'(sat_cnt), 32'd0);
        chk("t2_idle_after", 32'({ready, en_out}), 32'b10);
`ifdef STREAM_ENC_SPREAD_EN
        chk("t3_pattern", pat3, 32'hAAAA_AAAA);
`else
        chk("t3_pattern", pat3, 32'h0000_FFFF);
`endif

        // Back-to-back frames with new values each frame
        set_vals($urandom_range(0, 63), $urandom_range(0, 63),
                 $urandom_range(0, 63), $urandom_range(0, 63));
        fv[0] = int'(v1); fv[1] = int'(v2); fv[2] = int'(v3); fv[3] = int'(v4);
        en_in = 1'b1;
        step();
        for (int i = 0; i < 4; i++) t4_ones[i] = 0;
        en_hi = 0;
        for (int c = 0; c < 3 * F; c++) begin
            en_hi += int'(en_out);
            t4_ones[0] += int'(out1); t4_ones[1] += int'(out2);
            t4_ones[2] += int'(out3); t4_ones[3] += int'(out4);
            if (c % F == F - 1) begin
                for (int i = 0; i < 4; i++) begin
                    chk("t4_ones", 32'(t4_ones[i]), 32'(clampv(fv[i])));
                    t4_ones[i] = 0;
                end
                if (c == 3 * F - 1) begin
                    en_in = 1'b0;
                end else begin
                    set_vals($urandom_range(0, 63), $urandom_range(0, 63),
                             $urandom_range(0, 63), $urandom_range(0, 63));
                    fv[0] = int'(v1); fv[1] = int'(v2); fv[2] = int'(v3); fv[3] = int'(v4);
                end
            end
            step();
        end
        chk("t4_contig", 32'(en_hi), 32'(3 * F));

        // Saturation, then a non-saturating frame
        cap_frame(63, 10, 40, 0);
        chk("t5_ones1", 32'(ones[0]), 32'd32);
        chk("t5_ones3", 32'(ones[2]), 32'd32);
        chk("t5_sat", 32'(sat_cnt), 32'd32);
        cap_frame(7, 10, 20, 0);
        chk("t5b_ones1", 32'(ones[0]), 32'd7);
        chk("t5b_sat", 32'(sat_cnt), 32'd0);

        // Reset mid-frame, with a simultaneous request that must be dropped
        set_vals(20, 3, 32, 9);
        en_in = 1'b1;
        step();
        en_in = 1'b0;
        repeat (10) step();
        chk("t6_mid_en", 32'(en_out), 32'd1);
        rst = 1'b1;
        en_in = 1'b1;
        step();
        chk("t6_rst_outs", 32'({ready, en_out, frame_end, sat, out4, out3, out2, out1}), 32'd0);
        step();
        chk("t6_rst_drop", 32'(en_out), 32'd0);
        rst = 1'b0;
        en_in = 1'b0;
        step();
        chk("t6_ready", 32'({ready, en_out}), 32'b10);
        cap_frame(20, 3, 32, 9);
        chk("t6_full_frame", 32'(en_cnt), 32'd32);
        chk("t6_ones1", 32'(ones[0]), 32'd20);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            en_in = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 59) == 0);
            set_vals($urandom_range(0, 63), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 63));
            step();
        end
        rst = 1'b0;
        en_in = 1'b0;
        repeat (F + 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
